// File: rtl/seg7_scan4_if.sv
// Bus bundle for the four-digit seven-segment scanner.
// master: the side that supplies the digit data (DIGITS, DP_IN, BLANK_LZ)
//         and observes the display drive.
// slave : the scanner itself; it consumes the digit data and drives
//         AN, SEG, DP and FRAME.
// Signal summary:
//   DIGITS   [15:0] four BCD nibbles, DIGITS[3:0] = rightmost digit
//   DP_IN    [3:0]  decimal-point request per digit, active-high
//   BLANK_LZ        leading-zero blanking enable, active-high
//   AN       [3:0]  digit enables, active-low
//   SEG      [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   DP              decimal point, active-low
//   FRAME           one-cycle pulse after each input snapshot
interface seg7_scan4_if;
    logic [15:0] DIGITS;
    logic [3:0]  DP_IN;
    logic        BLANK_LZ;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        FRAME;

    modport master (
        output DIGITS, DP_IN, BLANK_LZ,
        input  AN, SEG, DP, FRAME
    );

    modport slave (
        input  DIGITS, DP_IN, BLANK_LZ,
        output AN, SEG, DP, FRAME
    );
endinterface

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed seven-segment display scanner.
// A prescaler divides CLK so that each digit is selected for SCAN_MAX
// cycles. The digit data is captured into a snapshot once per frame, on
// the tick that wraps the digit index from 3 back to 0, so the shown
// value never tears mid-frame. The first cycle of every digit slot is a
// dead-time cycle with all anodes off to avoid ghosting.
// Ports:
//   CLK    sole clock, rising edge
//   RESET  synchronous, active-high reset
//   bus    seg7_scan4_if.slave: DIGITS/DP_IN/BLANK_LZ in, AN/SEG/DP/FRAME out
// All bus outputs are registered (one cycle after the state they reflect).
module seg7_scan4 #(
    parameter int unsigned SCAN_MAX = 100000
) (
    input  logic         CLK,
    input  logic         RESET,
    seg7_scan4_if.slave  bus
);

    localparam int unsigned CNT_W    = (SCAN_MAX > 1) ? $clog2(SCAN_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_MAX - 1);
    localparam logic [6:0]  SEG_OFF  = 7'b1111111;
    localparam logic [6:0]  SEG_DASH = 7'b0111111;
    localparam logic [3:0]  AN_OFF   = 4'b1111;

    // Scan state
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       idx_q,   idx_d;

    // Frame snapshot of the inputs
    logic [15:0]      snap_dig_q,   snap_dig_d;
    logic [3:0]       snap_dp_q,    snap_dp_d;
    logic             snap_blank_q, snap_blank_d;

    // Registered outputs
    logic [3:0]       an_q,    an_d;
    logic [6:0]       seg_q,   seg_d;
    logic             dp_q,    dp_d;
    logic             frame_q, frame_d;

    // Combinational helpers
    logic             tick_c;
    logic             wrap_c;
    logic [3:0]       nib_c;
    logic [3:0]       zero_from_c;
    logic             blank_c;

    // BCD to active-low segments; non-decimal nibbles show a dash.
    function automatic logic [6:0] bcd_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

    // Next-state and next-output logic
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_dig_d   = snap_dig_q;
        snap_dp_d    = snap_dp_q;
        snap_blank_d = snap_blank_q;
        an_d         = AN_OFF;
        seg_d        = SEG_OFF;
        dp_d         = 1'b1;
        frame_d      = 1'b0;
        nib_c        = 4'd0;
        zero_from_c  = 4'd0;
        blank_c      = 1'b0;

        tick_c = (cnt_q == CNT_LAST);
        wrap_c = tick_c && (idx_q == 2'd3);

        // Prescaler and digit index
        if (tick_c) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Snapshot loads on the 3->0 wrap; FRAME marks it one cycle later
        if (wrap_c) begin
            snap_dig_d   = bus.DIGITS;
            snap_dp_d    = bus.DP_IN;
            snap_blank_d = bus.BLANK_LZ;
            frame_d      = 1'b1;
        end

        case (idx_q)
            2'd0:    nib_c = snap_dig_q[3:0];
            2'd1:    nib_c = snap_dig_q[7:4];
            2'd2:    nib_c = snap_dig_q[11:8];
            default: nib_c = snap_dig_q[15:12];
        endcase

        // zero_from_c[k]: nibbles k..3 are all zero; digit0 is never blanked
        zero_from_c[3] = (snap_dig_q[15:12] == 4'd0);
        zero_from_c[2] = zero_from_c[3] && (snap_dig_q[11:8] == 4'd0);
        zero_from_c[1] = zero_from_c[2] && (snap_dig_q[7:4] == 4'd0);
        zero_from_c[0] = 1'b0;
        blank_c        = snap_blank_q && zero_from_c[idx_q];

        // First cycle of each slot is dead time: anodes off, SEG/DP still valid
        if (cnt_q == '0) begin
            an_d = AN_OFF;
        end else begin
            an_d = ~(4'b0001 << idx_q);
        end
        seg_d = blank_c ? SEG_OFF : bcd_decode(nib_c);
        dp_d  = ~snap_dp_q[idx_q];
    end

    // State and output registers; reset overrides any coincident tick/load
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            snap_dig_q   <= 16'd0;
            snap_dp_q    <= 4'd0;
            snap_blank_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            frame_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_dig_q   <= snap_dig_d;
            snap_dp_q    <= snap_dp_d;
            snap_blank_q <= snap_blank_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_q      <= frame_d;
        end
    end

    assign bus.AN    = an_q;
    assign bus.SEG   = seg_q;
    assign bus.DP    = dp_q;
    assign bus.FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan4.sv
// Self-checking bench for seg7_scan4 with SCAN_MAX=4. A cycle-count based
// reference model predicts every output each cycle; directed phases cover
// the documented scenarios and a random phase follows.
module tb_seg7_scan4;

    localparam int SM     = 4;
    localparam int FRAME_LEN = 4 * SM;

    logic CLK;
    logic RESET;

    seg7_scan4_if bus ();

    seg7_scan4 #(.SCAN_MAX(SM)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int total;
    int bad;

    // Reference model: cycles since reset release plus the frame snapshot
    int          m_t;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic        m_blank;
    logic [6:0]  seg_tbl [16];

    // Frame period tracking
    int  since_frame;
    bit  have_frame;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0d time=%0t", tag, got, exp, m_t, $time);
        end
    endtask

    // One clock: predict, clock, sample #1 after edge, compare.
    task automatic step(input logic rst_in);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_frame;
        int c, i, nib;
        bit blank;
        RESET = rst_in;
        if (rst_in) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
        end else begin
            c     = m_t % SM;
            i     = (m_t / SM) % 4;
            nib   = (m_dig >> (4 * i)) & 16'hF;
            blank = m_blank && (i > 0) && ((m_dig >> (4 * i)) == 16'd0);
            e_an  = (c == 0) ? 4'hF : 4'((~(1 << i)) & 4'hF);
            e_seg = blank ? 7'h7F : seg_tbl[nib];
            e_dp  = ~m_dp[i];
            e_frame = (c == SM - 1) && (i == 3);
        end
        @(posedge CLK);
        if (rst_in) begin
            m_t = 0; m_dig = 16'd0; m_dp = 4'd0; m_blank = 1'b0;
            have_frame = 0;
        end else begin
            if (e_frame) begin
                m_dig = bus.DIGITS; m_dp = bus.DP_IN; m_blank = bus.BLANK_LZ;
            end
            m_t++;
        end
        #1;
        check("an",    16'(bus.AN),    16'(e_an));
        check("seg",   16'(bus.SEG),   16'(e_seg));
        check("dp",    16'(bus.DP),    16'(e_dp));
        check("frame", 16'(bus.FRAME), 16'(e_frame));
        check("an_onecold", 16'($countones(~bus.AN) <= 1), 16'd1);
        if (!rst_in) begin
            since_frame++;
            if (bus.FRAME === 1'b1) begin
                if (have_frame) check("frame_period", 16'(since_frame), 16'(FRAME_LEN));
                have_frame  = 1;
                since_frame = 0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    initial begin
        bit found;
        total = 0; bad = 0;
        m_t = 0; m_dig = 0; m_dp = 0; m_blank = 0;
        since_frame = 0; have_frame = 0;
        seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001;
        seg_tbl[2] = 7'b0100100; seg_tbl[3] = 7'b0110000;
        seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
        seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000;
        seg_tbl[8] = 7'b0000000; seg_tbl[9] = 7'b0010000;
        for (int k = 10; k < 16; k++) seg_tbl[k] = 7'b0111111;

        RESET = 1'b1;
        bus.DIGITS = 16'h0000; bus.DP_IN = 4'd0; bus.BLANK_LZ = 1'b0;

        // Reset, then 1234 for several frames
        step(1'b1); step(1'b1); step(1'b1);
        bus.DIGITS = 16'h1234;
        run(3 * FRAME_LEN + 2);

        // Leading-zero blanking on and off
        bus.DIGITS = 16'h0007; bus.BLANK_LZ = 1'b1;
        run(2 * FRAME_LEN);
        bus.BLANK_LZ = 1'b0;
        run(2 * FRAME_LEN);

        // Mid-frame input change stays invisible until the next snapshot
        bus.DIGITS = 16'h1111;
        run(FRAME_LEN + 6);
        bus.DIGITS = 16'h8888;
        run(2 * FRAME_LEN);

        // Hex nibbles as dashes, decimal point on digit 2
        bus.DIGITS = 16'hF0A0; bus.DP_IN = 4'b0100; bus.BLANK_LZ = 1'b1;
        run(2 * FRAME_LEN);

        // Reset with index=2, prescaler=3 (bounded search)
        found = 0;
        for (int k = 0; k < 2 * FRAME_LEN && !found; k++) begin
            if ((m_t % SM == 3) && ((m_t / SM) % 4 == 2)) found = 1;
            else step(1'b0);
        end
        check("reset_point_found", 16'(found), 16'd1);
        step(1'b1);
        bus.DIGITS = 16'h5678; bus.DP_IN = 4'b0001; bus.BLANK_LZ = 1'b0;
        run(2 * FRAME_LEN);

        // Random inputs with occasional resets
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.DIGITS = 16'($urandom);
                case ($urandom_range(0, 3))
                    0: bus.DIGITS = bus.DIGITS & 16'h000F;
                    1: bus.DIGITS = bus.DIGITS & 16'h00FF;
                    2: bus.DIGITS = bus.DIGITS & 16'h0FFF;
                    default: ;
                endcase
                bus.DP_IN    = 4'($urandom);
                bus.BLANK_LZ = 1'($urandom);
            end
            step($urandom_range(0, 79) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
